bubble_mem_arbiter: RTL and testbench

- Arbitrates a single-port data memory between two requesters: the CSE-Bubble processor's load/store path (cpu) and a host loader/debug port (host), e.g. a bench preloading or dumping memory.
- Sits between `Processor` and the data memory array.
- Each request is sequenced through issue, read-latency wait and response using a small FSM.
- Ties are resolved round-robin, or by fixed cpu priority when configured.

---
 rtl/bubble_mem_arbiter_if.sv | 67 ++++++
 rtl/bubble_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_bubble_mem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bubble_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// bubble_mem_arbiter_if
// Bundles the signals between the data-memory arbiter, its two requesters
// (cpu load/store path and host loader/debug port) and the single-port
// data memory.
//
// Signals:
//   cpu_req/we/addr/wdata    cpu request and payload (held until cpu_gnt)
//   cpu_gnt, cpu_rvalid      one-cycle pulses: access issued / read data valid
//   cpu_rdata                read result
//   host_*                   same set for the host port
//   mem_en/we/addr/wdata     memory access strobe, write enable, address, data
//   mem_rdata                memory read data (MEM_LAT cycles after mem_en)
//   busy                     arbiter FSM is not idle
//
// Modports:
//   master  requester/memory side (drives requests and mem_rdata)
//   slave   the arbiter itself
// ---------------------------------------------------------------------------
interface bubble_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );
endinterface

// File: rtl/bubble_mem_arbiter.sv
// ---------------------------------------------------------------------------
// bubble_mem_arbiter
// Shares one single-port data memory between the CSE-Bubble processor's
// load/store path (cpu) and a host loader/debug port (host). One access is
// outstanding at a time; each is walked through IDLE -> ISSUE -> (WAIT ->
// RESP | DONE) -> IDLE. Ties go round-robin, or always to the cpu when
// CPU_PRIORITY = 1. Every output is a register.
//
// Parameters:
//   ADDR_W        memory word-address width
//   DATA_W        data word width
//   MEM_LAT       memory read latency in cycles (1..4)
//   CPU_PRIORITY  0 = round-robin ties, 1 = cpu wins ties
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   bubble_mem_arbiter_if.slave (requesters, memory, busy)
// ---------------------------------------------------------------------------
module bubble_mem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int CPU_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  bubble_mem_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);
  localparam logic       PRIO_CPU = (CPU_PRIORITY != 0);

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic              any_req;
  logic              pick_cpu;
  logic              start;
  logic              capture;

  logic              win_cpu;
  logic              last_cpu;

  logic              cpu_gnt_q, host_gnt_q;
  logic              cpu_rvalid_q, host_rvalid_q;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              busy_q;

  // Arbitration and next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    capture   = 1'b0;
    any_req   = bus.cpu_req | bus.host_req;
    // cpu wins if it is alone, if priority is fixed, or if host won last time
    pick_cpu  = bus.cpu_req & (~bus.host_req | PRIO_CPU | ~last_cpu);

    case (state)
      IDLE: begin
        if (any_req) begin
          start     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_we_q) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt   = LAT_INIT;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 3'd1;
        // mem_rdata is valid in the cycle the countdown reaches 1
        if (cnt == 3'd1) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Registered outputs, winner tracking and memory-side payload
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cpu       <= 1'b0;
      last_cpu      <= 1'b0;
      cpu_gnt_q     <= 1'b0;
      host_gnt_q    <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rdata_q       <= '0;
      busy_q        <= 1'b0;
    end else begin
      cpu_gnt_q     <= start & pick_cpu;
      host_gnt_q    <= start & ~pick_cpu;
      mem_en_q      <= start;
      cpu_rvalid_q  <= capture & win_cpu;
      host_rvalid_q <= capture & ~win_cpu;
      busy_q        <= (state_nxt != IDLE);
      if (start) begin
        win_cpu     <= pick_cpu;
        last_cpu    <= pick_cpu;
        mem_we_q    <= pick_cpu ? bus.cpu_we    : bus.host_we;
        mem_addr_q  <= pick_cpu ? bus.cpu_addr  : bus.host_addr;
        mem_wdata_q <= pick_cpu ? bus.cpu_wdata : bus.host_wdata;
      end
      if (capture) begin
        rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.cpu_gnt     = cpu_gnt_q;
  assign bus.host_gnt    = host_gnt_q;
  assign bus.cpu_rvalid  = cpu_rvalid_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.cpu_rdata   = rdata_q;
  assign bus.host_rdata  = rdata_q;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_bubble_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bubble_mem_arbiter
// Four arbiter instances share one stimulus stream, each with its own
// latency-accurate memory model:
//   0: MEM_LAT=1, round-robin   1: MEM_LAT=1, cpu priority
//   2: MEM_LAT=3, round-robin   3: MEM_LAT=4, round-robin
// Cycle-by-cycle vectors exercise instance 0; short hand-written sequences
// cover priority, latency, reset-abort and request-while-busy cases.
// ---------------------------------------------------------------------------
module tb_bubble_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, host_req, host_we;
  logic [9:0]  cpu_addr, host_addr;
  logic [31:0] cpu_wdata, host_wdata;

  // status bits: {cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, mem_en, mem_we, busy}
  logic [6:0]  st_a  [4];
  logic [31:0] crd_a [4];
  logic [31:0] hrd_a [4];
  logic [31:0] wd_a  [4];
  logic [9:0]  ad_a  [4];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    localparam int LAT  = (g == 2) ? 3 : (g == 3) ? 4 : 1;
    localparam int PRIO = (g == 1) ? 1 : 0;

    bubble_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    logic [31:0] mem  [1024];
    logic [31:0] pipe [4];

    assign bus.cpu_req    = cpu_req;
    assign bus.cpu_we     = cpu_we;
    assign bus.cpu_addr   = cpu_addr;
    assign bus.cpu_wdata  = cpu_wdata;
    assign bus.host_req   = host_req;
    assign bus.host_we    = host_we;
    assign bus.host_addr  = host_addr;
    assign bus.host_wdata = host_wdata;

    bubble_mem_arbiter #(
      .ADDR_W(10), .DATA_W(32), .MEM_LAT(LAT), .CPU_PRIORITY(PRIO)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    // Read data appears exactly LAT cycles after the mem_en cycle; any other
    // cycle carries a poison word so a mistimed capture is visible.
    always_ff @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr] : 32'hBAD0BAD0;
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign bus.mem_rdata = pipe[LAT-1];

    assign st_a[g]  = {bus.cpu_gnt, bus.cpu_rvalid, bus.host_gnt, bus.host_rvalid,
                       bus.mem_en, bus.mem_we, bus.busy};
    assign crd_a[g] = bus.cpu_rdata;
    assign hrd_a[g] = bus.host_rdata;
    assign wd_a[g]  = bus.mem_wdata;
    assign ad_a[g]  = bus.mem_addr;
  end

  typedef struct {
    logic        rst;
    logic        creq, cwe;
    logic [9:0]  ca;
    logic [31:0] cd;
    logic        hreq, hwe;
    logic [9:0]  ha;
    logic [31:0] hd;
    logic [6:0]  st;   // expected status bits
    logic [9:0]  ea;   // expected mem_addr when mem_en
    logic [31:0] ed;   // expected mem_wdata on writes / rdata on rvalid
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, input logic cq, input logic cw,
                             input logic [9:0] ca, input logic [31:0] cd,
                             input logic hq, input logic hw,
                             input logic [9:0] ha, input logic [31:0] hd,
                             input logic [6:0] st, input logic [9:0] ea,
                             input logic [31:0] ed);
    vec_t x;
    x.rst = r;  x.creq = cq; x.cwe = cw; x.ca = ca; x.cd = cd;
    x.hreq = hq; x.hwe = hw; x.ha = ha; x.hd = hd;
    x.st = st;  x.ea = ea;   x.ed = ed;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cq, input logic cw, input logic [9:0] ca,
                       input logic [31:0] cd, input logic hq, input logic hw,
                       input logic [9:0] ha, input logic [31:0] hd);
    cpu_req = cq;  cpu_we = cw;  cpu_addr = ca;  cpu_wdata = cd;
    host_req = hq; host_we = hw; host_addr = ha; host_wdata = hd;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [6:0]  mask;
    logic [31:0] rd;
    int cg_n, hg_n, cr_n, ovl, first_g, first_r, bad;
    bit seen;

    // ---------------- reset state, all instances
    do_reset();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("reset_status_dut%0d", d), {25'd0, st_a[d]}, 32'd0);
      chk($sformatf("reset_rdata_dut%0d", d), crd_a[d], 32'd0);
    end

    // ---------------- vectors: cpu write then read, then round-robin (dut0)
    tbl.push_back(v(0, 1,1,10'd5,32'hDEADBEEF, 0,0,0,0, 7'b0000000, 0, 0));
    tbl.push_back(v(0, 1,1,10'd5,32'hDEADBEEF, 0,0,0,0, 7'b1000111, 10'd5, 32'hDEADBEEF));
    tbl.push_back(v(0, 0,0,0,0,                0,0,0,0, 7'b0000001, 0, 0));
    tbl.push_back(v(0, 1,0,10'd5,0,            0,0,0,0, 7'b0000000, 0, 0));
    tbl.push_back(v(0, 1,0,10'd5,0,            0,0,0,0, 7'b1000101, 10'd5, 0));
    tbl.push_back(v(0, 0,0,0,0,                0,0,0,0, 7'b0000001, 0, 0));
    tbl.push_back(v(0, 0,0,0,0,                0,0,0,0, 7'b0100001, 0, 32'hDEADBEEF));
    tbl.push_back(v(0, 0,0,0,0,                0,0,0,0, 7'b0000000, 0, 0));
    // reset returns last-winner to host; preload own addresses
    tbl.push_back(v(1, 0,0,0,0, 0,0,0,0, 7'b0000000, 0, 0));
    tbl.push_back(v(0, 1,1,10'h10,32'h11110010, 0,0,0,0, 7'b0000000, 0, 0));
    tbl.push_back(v(0, 1,1,10'h10,32'h11110010, 0,0,0,0, 7'b1000111, 10'h10, 32'h11110010));
    tbl.push_back(v(0, 0,0,0,0, 0,0,0,0, 7'b0000001, 0, 0));
    tbl.push_back(v(0, 0,0,0,0, 1,1,10'h20,32'h22220020, 7'b0000000, 0, 0));
    tbl.push_back(v(0, 0,0,0,0, 1,1,10'h20,32'h22220020, 7'b0010111, 10'h20, 32'h22220020));
    tbl.push_back(v(0, 0,0,0,0, 0,0,0,0, 7'b0000001, 0, 0));
    // both hold reads: expected order cpu, host, cpu, host
    for (int t = 0; t < 2; t++) begin
      tbl.push_back(v(0, 1,0,10'h10,0, 1,0,10'h20,0, 7'b0000000, 0, 0));
      tbl.push_back(v(0, 1,0,10'h10,0, 1,0,10'h20,0, 7'b1000101, 10'h10, 0));
      tbl.push_back(v(0, 1,0,10'h10,0, 1,0,10'h20,0, 7'b0000001, 0, 0));
      tbl.push_back(v(0, 1,0,10'h10,0, 1,0,10'h20,0, 7'b0100001, 0, 32'h11110010));
      tbl.push_back(v(0, 1,0,10'h10,0, 1,0,10'h20,0, 7'b0000000, 0, 0));
      tbl.push_back(v(0, 1,0,10'h10,0, 1,0,10'h20,0, 7'b0010101, 10'h20, 0));
      tbl.push_back(v(0, 1,0,10'h10,0, 1,0,10'h20,0, 7'b0000001, 0, 0));
      tbl.push_back(v(0, (t == 0),0,10'h10,0, (t == 0),0,10'h20,0, 7'b0001001, 0, 32'h22220020));
    end
    tbl.push_back(v(0, 0,0,0,0, 0,0,0,0, 7'b0000000, 0, 0));

    foreach (tbl[i]) begin
      step();
      mask = tbl[i].st[2] ? 7'h7F : 7'h7D;  // mem_we only meaningful with mem_en
      chk($sformatf("vec%0d_status", i), {25'd0, st_a[0] & mask}, {25'd0, tbl[i].st});
      if (tbl[i].st[2])
        chk($sformatf("vec%0d_mem_addr", i), {22'd0, ad_a[0]}, {22'd0, tbl[i].ea});
      if (tbl[i].st[2] && tbl[i].st[1])
        chk($sformatf("vec%0d_mem_wdata", i), wd_a[0], tbl[i].ed);
      if (tbl[i].st[5])
        chk($sformatf("vec%0d_cpu_rdata", i), crd_a[0], tbl[i].ed);
      if (tbl[i].st[3])
        chk($sformatf("vec%0d_host_rdata", i), hrd_a[0], tbl[i].ed);
      rst = tbl[i].rst;
      drive(tbl[i].creq, tbl[i].cwe, tbl[i].ca, tbl[i].cd,
            tbl[i].hreq, tbl[i].hwe, tbl[i].ha, tbl[i].hd);
    end

    // ---------------- fixed cpu priority (dut1)
    do_reset();
    drive(1, 0, 10'h10, 0, 1, 0, 10'h20, 0);
    cg_n = 0; hg_n = 0; cr_n = 0; ovl = 0;
    for (int c = 0; c < 40 && cr_n < 3; c++) begin
      step();
      cg_n += int'(st_a[1][6]);
      hg_n += int'(st_a[1][4]);
      if ((st_a[1][6] | st_a[1][4]) & (st_a[1][5] | st_a[1][3])) ovl++;
      if (st_a[1][5]) begin
        cr_n++;
        chk("prio_cpu_rdata", crd_a[1], 32'h11110010);
      end
    end
    chk("prio_cpu_rvalid_count", 32'(cr_n), 32'd3);
    chk("prio_cpu_gnt_count", 32'(cg_n), 32'd3);
    chk("prio_host_gnt_count", 32'(hg_n), 32'd0);
    chk("prio_gnt_rvalid_overlap", 32'(ovl), 32'd0);
    drive(0, 0, 0, 0, 1, 0, 10'h20, 0);   // cpu drops in its RESP cycle
    step();
    chk("prio_host_gnt_in_idle", {31'd0, st_a[1][4]}, 32'd0);
    step();
    chk("prio_host_gnt_after_drop", {30'd0, st_a[1][6], st_a[1][4]}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // ---------------- MEM_LAT = 3 host read of top address (dut2)
    do_reset();
    drive(0, 0, 0, 0, 1, 1, 10'h3FF, 32'h12345678);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      seen = st_a[2][4];
    end
    chk("lat3_write_gnt", {31'd0, seen}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      seen = !st_a[2][0];
    end
    chk("lat3_write_idle", {31'd0, seen}, 32'd1);
    drive(0, 0, 0, 0, 1, 0, 10'h3FF, 0);   // cycle 0
    first_g = -1; first_r = -1; rd = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (st_a[2][4] && first_g < 0) begin
        first_g = c;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
      end
      if (st_a[2][3] && first_r < 0) begin
        first_r = c;
        rd = hrd_a[2];
      end
    end
    chk("lat3_host_gnt_cycle", 32'(first_g), 32'd1);
    chk("lat3_host_rvalid_cycle", 32'(first_r), 32'd5);
    chk("lat3_host_rdata", rd, 32'h12345678);

    // ---------------- reset during WAIT, MEM_LAT = 4 (dut3)
    do_reset();
    drive(1, 0, 10'h10, 0, 0, 0, 0, 0);   // cycle 0
    step();                                // cycle 1
    chk("rst_abort_gnt", {31'd0, st_a[3][6]}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();                                // cycle 2: WAIT
    step();                                // cycle 3: WAIT
    rst = 1'b1;
    step();                                // cycle 4
    rst = 1'b0;
    chk("rst_abort_status", {25'd0, st_a[3]}, 32'd0);
    chk("rst_abort_mem_addr", {22'd0, ad_a[3]}, 32'd0);
    chk("rst_abort_rdata", crd_a[3], 32'd0);
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (st_a[3] != 7'd0) bad++;
    end
    chk("rst_abort_quiet", 32'(bad), 32'd0);
    drive(1, 0, 10'h10, 0, 1, 0, 10'h20, 0);
    step();
    chk("rst_first_tie_cpu", {30'd0, st_a[3][6], st_a[3][4]}, 32'd2);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    seen = 0;
    for (int c = 0; c < 12 && !seen; c++) begin
      step();
      seen = !st_a[3][0];
    end
    chk("rst_tie_done", {31'd0, seen}, 32'd1);

    // ---------------- host request raised during cpu write (dut0)
    do_reset();
    drive(1, 1, 10'd7, 32'h00007777, 0, 0, 0, 0);   // cycle 0
    step();                                          // cycle 1: ISSUE
    chk("busy_req_cpu_gnt", {31'd0, st_a[0][6]}, 32'd1);
    drive(1, 1, 10'd7, 32'h00007777, 1, 0, 10'd5, 0);
    first_g = -1; first_r = -1; rd = 0; bad = 0;
    for (int c = 2; c <= 10; c++) begin
      step();
      if (c == 2) drive(0, 0, 0, 0, 1, 0, 10'd5, 0);
      if (st_a[0][5] || st_a[0][6]) bad++;
      if (st_a[0][4] && first_g < 0) begin
        first_g = c;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
      end
      if (st_a[0][3] && first_r < 0) begin
        first_r = c;
        rd = hrd_a[0];
      end
    end
    chk("busy_req_host_gnt_cycle", 32'(first_g), 32'd4);
    chk("busy_req_host_rvalid_cycle", 32'(first_r), 32'd6);
    chk("busy_req_host_rdata", rd, 32'hDEADBEEF);
    chk("busy_req_no_cpu_pulses", 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
